// File: rtl/audipus_audio_pkg.sv
// Shared audio constants and types for the I2S DAC transmit path.
// Frame geometry: 512 master clocks per stereo frame = 2 slots x 32 bits x 8 clocks.
// Derived widths: counter, bit-clock shift and slot bit index.
package audipus_audio_pkg;

  localparam int FRAME_CLKS = 512;
  localparam int BCLK_DIV   = 8;
  localparam int SLOT_WIDTH = 32;
  localparam int DATA_WIDTH = 24;
  localparam int MCLK_HZ    = 49152000;

  // Derived widths. The frame is exactly two slots of SLOT_WIDTH bclk periods,
  // so the counter splits cleanly into {channel, bit slot, bclk phase}.
  localparam int CNT_W   = $clog2(FRAME_CLKS);
  localparam int BCLK_SH = $clog2(BCLK_DIV);
  localparam int BIT_W   = $clog2(SLOT_WIDTH);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic [CNT_W-1:0]             cnt_t;
  typedef logic [BIT_W-1:0]             bit_idx_t;

endpackage

// File: rtl/i2s_frame_timer.sv
// Frame timer: owns the frame counter and produces bclk, lrclk, bit slot index,
// channel and the frame-load strobe.
// Ports: clk_i, reset_n_i (sync, active-low), run_i (low = idle, counter held at 0);
//        bclk_o/lrclk_o registered (one clk behind cnt); bit_idx_o/ch_o/load_o
//        are decodes of the current count for the serialiser in the parent.
// Optional: I2S_TX_LEFT_JUSTIFIED_EN inverts lrclk (high = left).
module i2s_frame_timer
  import audipus_audio_pkg::*;
(
  input  logic     clk_i,
  input  logic     reset_n_i,
  input  logic     run_i,
  output logic     bclk_o,
  output logic     lrclk_o,
  output bit_idx_t bit_idx_o,
  output logic     ch_o,
  output logic     load_o
);

  localparam cnt_t CNT_LAST = cnt_t'(FRAME_CLKS - 1);

  cnt_t cnt_q, cnt_d;
  logic bclk_q, bclk_d;
  logic lrclk_q, lrclk_d;

  // Counter fields: {ch, bit slot, bclk phase}
  assign bit_idx_o = cnt_q[BCLK_SH +: BIT_W];
  assign ch_o      = cnt_q[CNT_W-1];
  assign load_o    = run_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d   = '0;
    bclk_d  = 1'b0;
    lrclk_d = 1'b0;
    if (run_i) begin
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      // Upper half of the bclk phase is high, so the falling edge lands on
      // phase 0 where sdata changes.
      bclk_d = cnt_q[BCLK_SH-1];
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      lrclk_d = ~ch_o;
`else
      lrclk_d = ch_o;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
    end
  end

  assign bclk_o  = bclk_q;
  assign lrclk_o = lrclk_q;

endmodule

// File: rtl/i2s_dac_transmitter.sv
// I2S DAC transmitter: one-deep pending buffer per channel, hold registers
// loaded at each frame boundary, MSB-first serialiser and status pulses.
// Ports: clk, reset_n (sync, active-low), run; l/r_din_valid + l/r_data_in in;
//        bclk, lrclk, sdata, frame_start, underrun, overrun out (all registered).
// Optional: I2S_TX_LEFT_JUSTIFIED_EN selects left-justified format (no 1-bit delay).
module i2s_dac_transmitter
  import audipus_audio_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  l_din_valid,
  input  logic                  r_din_valid,
  input  logic [DATA_WIDTH-1:0] l_data_in,
  input  logic [DATA_WIDTH-1:0] r_data_in,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  frame_start,
  output logic                  underrun,
  output logic                  overrun
);

  bit_idx_t bit_idx;
  logic     ch;
  logic     load;

  i2s_frame_timer u_timer (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .run_i     (run),
    .bclk_o    (bclk),
    .lrclk_o   (lrclk),
    .bit_idx_o (bit_idx),
    .ch_o      (ch),
    .load_o    (load)
  );

  sample_t pend_l_q, pend_l_d;
  sample_t pend_r_q, pend_r_d;
  logic    flag_l_q, flag_l_d;
  logic    flag_r_q, flag_r_d;
  sample_t hold_l_q, hold_l_d;
  sample_t hold_r_q, hold_r_d;
  logic    sdata_q, sdata_d;
  logic    frame_start_q, frame_start_d;
  logic    underrun_q, underrun_d;
  logic    overrun_q, overrun_d;

  logic     do_load;
  sample_t  word;
  bit_idx_t bit_sel;
  logic     bit_ok;

  // Boundary only commits when both channels are pending; otherwise the
  // previous pair repeats and any lone pending sample stays put.
  assign do_load = load && flag_l_q && flag_r_q;
  assign word    = ch ? hold_r_q : hold_l_q;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  assign bit_ok  = (bit_idx < bit_idx_t'(DATA_WIDTH));
  assign bit_sel = bit_idx_t'(DATA_WIDTH - 1) - bit_idx;
`else
  // Slot bit 0 is the I2S one-bit delay; MSB follows in slot bit 1.
  assign bit_ok  = (bit_idx != '0) && (bit_idx <= bit_idx_t'(DATA_WIDTH));
  assign bit_sel = bit_idx_t'(DATA_WIDTH) - bit_idx;
`endif

  always_comb begin
    pend_l_d      = pend_l_q;
    pend_r_d      = pend_r_q;
    flag_l_d      = flag_l_q;
    flag_r_d      = flag_r_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    sdata_d       = 1'b0;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    overrun_d     = 1'b0;

    if (!run) begin
      // Idle: drop pending flags, keep hold words for the restart.
      flag_l_d = 1'b0;
      flag_r_d = 1'b0;
    end else begin
      if (bit_ok) begin
        sdata_d = word[bit_sel];
      end

      frame_start_d = do_load;
      underrun_d    = load && !do_load;

      // A valid on the load cycle replaces a value that is being consumed,
      // so it is not an overwrite.
      overrun_d = !do_load && ((l_din_valid && flag_l_q) ||
                               (r_din_valid && flag_r_q));

      if (do_load) begin
        hold_l_d = pend_l_q;
        hold_r_d = pend_r_q;
        flag_l_d = 1'b0;
        flag_r_d = 1'b0;
      end

      // Capture after the load so a same-cycle valid re-sets its flag.
      if (l_din_valid) begin
        pend_l_d = l_data_in;
        flag_l_d = 1'b1;
      end
      if (r_din_valid) begin
        pend_r_d = r_data_in;
        flag_r_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_l_q      <= '0;
      pend_r_q      <= '0;
      flag_l_q      <= 1'b0;
      flag_r_q      <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      pend_l_q      <= pend_l_d;
      pend_r_q      <= pend_r_d;
      flag_l_q      <= flag_l_d;
      flag_r_q      <= flag_r_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      overrun_q     <= overrun_d;
    end
  end

  assign sdata       = sdata_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Bench for i2s_dac_transmitter: frame-level reference model (pending/hold words,
// slot bit patterns built from the sample words) checked every clock, plus
// directed scenarios and a randomized run.
module tb_i2s_dac_transmitter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic        l_din_valid;
  logic        r_din_valid;
  logic [23:0] l_data_in;
  logic [23:0] r_data_in;
  logic        bclk, lrclk, sdata, frame_start, underrun, overrun;

  always #5 clk = ~clk;

  i2s_dac_transmitter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .l_din_valid (l_din_valid),
    .r_din_valid (r_din_valid),
    .l_data_in   (l_data_in),
    .r_data_in   (r_data_in),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .frame_start (frame_start),
    .underrun    (underrun),
    .overrun     (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Whole 32-bit slot as it should appear on the wire, slot bit 0 in bit 31.
  function automatic logic [31:0] slot_exp(input logic [23:0] w);
    logic [31:0] s;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    s = {w, 8'h00};
`else
    s = {1'b0, w, 7'h00};
`endif
    return s;
  endfunction

  // Reference model state
  int          m_cnt;
  logic [23:0] m_pl, m_pr, m_hl, m_hr;
  bit          m_fl, m_fr;
  bit          e_bclk, e_lr, e_sd, e_fs, e_ur, e_ov;

  logic [31:0] cap_l, cap_r;
  int          fs_n, ur_n, ov_n;

  task automatic step();
    int          c;
    bit          active;
    bit          loaded;
    bit          boundary;
    int          b;
    logic [31:0] slot;
    c      = m_cnt;
    active = 1'b0;
    @(posedge clk);
    if (!reset_n) begin
      m_cnt = 0; m_pl = '0; m_pr = '0; m_hl = '0; m_hr = '0;
      m_fl = 0; m_fr = 0;
      {e_bclk, e_lr, e_sd, e_fs, e_ur, e_ov} = '0;
    end else if (!run) begin
      m_cnt = 0; m_fl = 0; m_fr = 0;
      {e_bclk, e_lr, e_sd, e_fs, e_ur, e_ov} = '0;
    end else begin
      active = 1'b1;
      b      = (c % 256) / 8;
      slot   = slot_exp((c >= 256) ? m_hr : m_hl);
      e_bclk = (c % 8) >= 4;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      e_lr   = !(c >= 256);
`else
      e_lr   = (c >= 256);
`endif
      e_sd     = slot[31-b];
      boundary = (c == 511);
      loaded   = boundary && m_fl && m_fr;
      e_fs     = loaded;
      e_ur     = boundary && !loaded;
      e_ov     = !loaded && ((l_din_valid && m_fl) || (r_din_valid && m_fr));
      if (loaded) begin
        m_hl = m_pl; m_hr = m_pr; m_fl = 0; m_fr = 0;
      end
      if (l_din_valid) begin m_pl = l_data_in; m_fl = 1; end
      if (r_din_valid) begin m_pr = r_data_in; m_fr = 1; end
      m_cnt = (c + 1) % 512;
    end
    @(negedge clk);
    chk("bclk", 32'(bclk), 32'(e_bclk));
    chk("lrclk", 32'(lrclk), 32'(e_lr));
    chk("sdata", 32'(sdata), 32'(e_sd));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("underrun", 32'(underrun), 32'(e_ur));
    chk("overrun", 32'(overrun), 32'(e_ov));
    fs_n += int'(frame_start);
    ur_n += int'(underrun);
    ov_n += int'(overrun);
    if (active && (c % 8) == 4) begin
      if (c < 256) cap_l[31 - (c / 8)] = sdata;
      else         cap_r[31 - ((c - 256) / 8)] = sdata;
    end
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (m_cnt != target) begin
      step();
      guard++;
      if (guard > 2000) begin
        chk("run_to_timeout", 32'(guard), 32'(0));
        break;
      end
    end
  endtask

  task automatic pulse(input bit lv, input bit rv, input logic [23:0] ld, input logic [23:0] rd);
    l_din_valid = lv; r_din_valid = rv; l_data_in = ld; r_data_in = rd;
    step();
    l_din_valid = 1'b0; r_din_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; run = 1'b1;
    l_din_valid = 1'b0; r_din_valid = 1'b0;
    l_data_in = '0; r_data_in = '0;
    m_cnt = 0; m_pl = '0; m_pr = '0; m_hl = '0; m_hr = '0; m_fl = 0; m_fr = 0;
    cap_l = '0; cap_r = '0; fs_n = 0; ur_n = 0; ov_n = 0;
    @(negedge clk);
    repeat (3) step();

    // Reset asserted mid-frame, then release.
    reset_n = 1'b1;
    run_to(300);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;

    // First pair loaded at the first boundary.
    run_to(10);
    pulse(1, 1, 24'h800001, 24'h7FFFFE);
    fs_n = 0;
    run_to(0);
    chk("t2_frame_start_count", 32'(fs_n), 32'(1));
    fs_n = 0; ur_n = 0;
    repeat (512) step();
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    chk("t2_left_slot", cap_l, 32'h80000100);
    chk("t2_right_slot", cap_r, 32'h7FFFFE00);
`else
    chk("t2_left_slot", cap_l, 32'h40000080);
    chk("t2_right_slot", cap_r, 32'h3FFFFF00);
`endif
    chk("t3_underrun_count", 32'(ur_n), 32'(1));

    // Underrun: previous words repeat.
    cap_l = '0; cap_r = '0;
    repeat (512) step();
    chk("t3_left_repeat", cap_l, slot_exp(24'h800001));
    chk("t3_right_repeat", cap_r, slot_exp(24'h7FFFFE));
    chk("t3_no_frame_start", 32'(fs_n), 32'(0));

    // Overrun on the left pending buffer.
    ov_n = 0;
    run_to(40);  pulse(1, 0, 24'h111111, 24'h0);
    run_to(100); pulse(1, 0, 24'h222222, 24'h0);
    run_to(150); pulse(0, 1, 24'h0, 24'h333333);
    run_to(0);
    chk("t4_overrun_count", 32'(ov_n), 32'(1));
    repeat (512) step();
    chk("t4_left_word", cap_l, slot_exp(24'h222222));
    chk("t4_right_word", cap_r, slot_exp(24'h333333));

    // Valids on the load cycle: old pair loads, new pair stays pending.
    run_to(20);
    pulse(1, 1, 24'hAAAAAA, 24'h555555);
    run_to(511);
    ov_n = 0;
    pulse(1, 1, 24'h123456, 24'h654321);
    fs_n = 0;
    repeat (512) step();
    chk("t5_left_old", cap_l, slot_exp(24'hAAAAAA));
    chk("t5_right_old", cap_r, slot_exp(24'h555555));
    chk("t5_no_overrun", 32'(ov_n), 32'(0));
    chk("t5_second_load", 32'(fs_n), 32'(1));
    repeat (512) step();
    chk("t5_left_new", cap_l, slot_exp(24'h123456));
    chk("t5_right_new", cap_r, slot_exp(24'h654321));

    // run dropped mid-frame with a full pending pair: flags must clear.
    run_to(100);
    pulse(1, 1, 24'h0F0F0F, 24'hF0F0F0);
    run_to(300);
    run = 1'b0;
    repeat (5) step();
    run = 1'b1;
    ur_n = 0; fs_n = 0;
    cap_l = '0; cap_r = '0;
    repeat (512) step();
    chk("t6_underrun", 32'(ur_n), 32'(1));
    chk("t6_no_load", 32'(fs_n), 32'(0));
    chk("t6_left_hold", cap_l, slot_exp(24'h123456));
    chk("t6_right_hold", cap_r, slot_exp(24'h654321));

    // Randomized traffic, occasional run drops.
    for (int i = 0; i < 24 * 512; i++) begin
      l_din_valid = ($urandom_range(0, 149) == 0);
      r_din_valid = ($urandom_range(0, 149) == 0);
      l_data_in   = 24'($urandom);
      r_data_in   = 24'($urandom);
      if ($urandom_range(0, 2999) == 0) run = 1'b0;
      step();
      if (!run && $urandom_range(0, 3) == 0) run = 1'b1;
    end
    l_din_valid = 1'b0; r_din_valid = 1'b0; run = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_dac_transmitter.md
Name: i2s_dac_transmitter

Overview:
- Serialises the 96 kHz stereo stream from the interpolator onto an I2S link to the DAC, with clk = mclk = 49.152 MHz.
- Generates bclk (mclk/8 = 6.144 MHz) and lrclk (mclk/512 = 96 kHz) from one frame counter.
- Accepts left and right samples on independent valid strobes into a one-deep pending buffer, then loads them into hold registers at each frame boundary.
- Reports underrun and overrun.

Parameters:
- FRAME_CLKS, 512, clk cycles per stereo frame (2 slots × 32 bits × 8 clk).
- BCLK_DIV, 8, clk cycles per bclk period; must be a power of 2.
- DATA_WIDTH, 24, sample width.
- SLOT_WIDTH, 32, bits per channel slot.

Ports:
- clk  in  1  master clock 49.152 MHz
- reset_n  in  1  synchronous, active-low reset
- run  in  1  enable; low = synchronous idle
- l_din_valid  in  1  strobe, l_data_in valid
- r_din_valid  in  1  strobe, r_data_in valid
- l_data_in  in  24  left sample, two's complement
- r_data_in  in  24  right sample, two's complement
- bclk  out  1  I2S bit clock
- lrclk  out  1  I2S word select
- sdata  out  1  I2S serial data
- frame_start  out  1  1-cycle pulse, new hold words loaded
- underrun  out  1  1-cycle pulse, boundary reached without both samples pending
- overrun  out  1  1-cycle pulse, pending sample overwritten

Behaviour:
- Reset (reset_n=0, sampled on posedge clk):
  - cnt=0; pend_l, pend_r and their flags cleared; hold_l=hold_r=0.
  - All outputs 0.
- Frame counter cnt[8:0]:
  - Increments every clk while run=1 and wraps 511→0.
  - Let b = cnt[7:3] (bit slot 0..31) and ch = cnt[8] (0 = left, 1 = right).
- Outputs are registered functions of cnt, one clk behind cnt, and mutually aligned:
  - bclk = cnt[2]: low for cnt[2:0] 0..3, high for 4..7. Falling edge at cnt[2:0]=0, where sdata changes; the DAC samples on the rising edge.
  - lrclk = ch (low = left).
  - sdata = word[DATA_WIDTH-b] for b in 1..24, else 0. word = hold_l when ch=0, hold_r when ch=1. This gives the I2S one-bit delay with MSB first; slot bits 25..31 are zero.
- Pending capture:
  - l_din_valid sets pend_l ← l_data_in and the l flag; the right channel behaves identically.
  - Valid while the flag is already set and no load occurs that cycle: overwrite, and overrun=1 for one cycle.
- Frame load, on the cycle cnt==511:
  - Both flags set: hold_l/hold_r ← pend values, flags cleared, frame_start pulses on the next cycle (aligned with cnt==0).
  - Otherwise: hold registers unchanged (previous frame repeats), flags unchanged, underrun pulses on the next cycle. A lone pending channel stays pending.
- Valid arriving on the load cycle:
  - The load uses the old pending value.
  - The new value is written to pending and its flag ends set (set wins over clear).
  - No overrun is flagged.
- run=0 (any time, including mid-frame):
  - Next cycle: cnt=0, bclk=lrclk=sdata=0, flags cleared, pulses 0.
  - Hold registers are retained. Restart begins at cnt=0 with the left slot.
- Latency: a sample pair pending at cnt==511 appears with its left MSB on sdata during cnt 8..15 of the next frame, plus the 1 clk output register.

Optional Feature:
- Macro: I2S_TX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format. No one-bit delay: sdata = word[DATA_WIDTH-1-b] for b in 0..23, else 0. lrclk is inverted (high = left).
- Undefined: standard I2S as described in Behaviour.

Decomposition:
- Package audipus_audio_pkg holds:
  - constants FRAME_CLKS, BCLK_DIV, SLOT_WIDTH, DATA_WIDTH, MCLK_HZ=49152000;
  - typedef sample_t = logic signed [23:0].
- One sub-module, i2s_frame_timer: owns cnt and emits bclk, lrclk, bit index, load strobe and channel. The top module holds the buffers and the serialiser.

Test Plan:
- Reset asserted mid-frame → next clk: all outputs 0, cnt=0, hold=0; after release with run=1, bclk period 8 clk and lrclk period 512 clk.
- l=0x800001, r=0x7FFFFE both pending before first cnt==511 → frame_start pulse. Left slot sdata = 0, then 1,0×22,1, then 0×7 with lrclk=0. Right slot = 0, 0,1×22,0, 0×7.
- No valids during a frame after a loaded frame → underrun pulse at cnt 0; same words retransmitted; frame_start stays 0.
- Two l_din_valid (0x111111 then 0x222222) plus one r before the boundary → one overrun pulse; left transmits 0x222222.
- l/r valid exactly on the cnt==511 cycle with earlier pending 0xAAAAAA/0x555555 → the earlier pair transmits. The new pair stays pending with no overrun, and loads at the next boundary.
- run dropped at cnt=300 for 5 clk → outputs 0 and flags cleared. On restart, hold words are retransmitted from the left slot and underrun pulses at the first boundary.
